multi_edge_det: RTL

Parametrised, multi-channel edge detector for the alarm clock's push-button and switch inputs. Each channel synchronises an asynchronous input, debounces it with a cycle counter, and emits a one-cycle pulse on the run-time-selected edge type (rise, fall, both, or off). Each channel also has a sticky event flag with per-channel clear, plus an OR-reduced interrupt. It sits between the board I/O and the clock/alarm control FSMs, replacing single-channel rising-edge detection.

---
 rtl/multi_edge_det.sv | 120 ++++++++++++
 1 files changed

// File: rtl/multi_edge_det.sv
// Multi-channel synchronise / debounce / edge-detect block for board push-buttons and switches.
// Each channel emits a one-cycle pulse on the selected edge, latches a sticky event flag, and feeds a shared irq.
module multi_edge_det #(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 4,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  input  logic [1:0]    edge_sel,
  input  logic [CH-1:0] clr,
  output logic [CH-1:0] level,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] evt,
  output logic          irq,
  output logic [CH-1:0] dbg_state
);

  localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } db_state_e;

  // Handshake note: this block has no valid/ready interfaces; every input is sampled
  // unconditionally on each rising clk edge and every output is a plain registered level.

  logic [SYNC_STAGES-1:0] sync_q  [CH];
  logic [CW-1:0]          cnt_q   [CH];
  logic [CW-1:0]          cnt_d   [CH];
  db_state_e              state_q [CH];
  db_state_e              state_d [CH];
  logic [CH-1:0]          s;
  logic [CH-1:0]          level_q, level_d;
  logic [CH-1:0]          pulse_q, pulse_d;
  logic [CH-1:0]          evt_q, evt_d;
  logic                   irq_q, irq_d;

  function automatic logic edge_match(input logic [1:0] sel, input logic rising);
    case (sel)
      2'b00:   return rising;
      2'b01:   return !rising;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    s = '0;
    for (int i = 0; i < CH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      if (s[i] == level_q[i]) begin
        cnt_d[i]   = '0;
        state_d[i] = ST_IDLE;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        state_d[i] = ST_IDLE;
        // The pulse_q guard only matters for DB_CYCLES=1, where toggles could land back to back.
        pulse_d[i] = edge_match(edge_sel, s[i]) && !pulse_q[i];
      end else begin
        cnt_d[i]   = cnt_q[i] + CW'(1);
        state_d[i] = ST_COUNT;
      end
    end
    // Set wins over clear when a pulse and a clear meet on the same channel.
    evt_d = pulse_q | (evt_q & ~clr);
    irq_d = |evt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i]  <= {SYNC_STAGES{IDLE_LEVEL}};
        cnt_q[i]   <= '0;
        state_q[i] <= ST_IDLE;
      end
      level_q <= {CH{IDLE_LEVEL}};
      pulse_q <= '0;
      evt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
      evt_q   <= evt_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < CH; i++) begin
      dbg_state[i] = (state_q[i] == ST_COUNT);
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign evt   = evt_q;
  assign irq   = irq_q;

endmodule
